// File: rtl/frame_sequencer.sv
// Per-frame scheduler: turns frame clock edges into a swap/clear/render pass
// with start/done handshakes, overrun accounting and a per-phase watchdog.
module frame_sequencer #(
   parameter int TIMEOUT_CYCLES = 833333,
   parameter int FRAME_W        = 16,
   parameter int OVR_W          = 8
) (
   input  logic               clk_50mhz,
   input  logic               rst,
   input  logic               frame_clk,
   input  logic               enable,
   input  logic               clr_status,
   input  logic               swap_done,
   input  logic               clear_done,
   input  logic               render_done,
   output logic               swap_start,
   output logic               clear_start,
   output logic               render_start,
   output logic               busy,
   output logic [FRAME_W-1:0] frame_count,
   output logic               overrun,
   output logic [OVR_W-1:0]   overrun_count,
   output logic               fault
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SWAP,
      CLEAR,
      RENDER
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            frame_clk_d;
   logic            tick;
   logic            frame_ready;
   logic            ready_nx;
   logic [WD_W-1:0] wdog;
   logic            done_ok;
   logic            timeout;
   logic            frame_inc;
   logic            fault_set;
   logic            ovr_hit;

   assign tick    = frame_clk & ~frame_clk_d;
   assign busy    = (state != IDLE);
   assign ovr_hit = tick & busy;

   // A done is only honoured after its phase's start-pulse cycle.
   always_comb begin
      done_ok = 1'b0;
      unique case (state)
         IDLE:   done_ok = 1'b0;
         SWAP:   done_ok = swap_done & ~swap_start;
         CLEAR:  done_ok = clear_done & ~clear_start;
         RENDER: done_ok = render_done & ~render_start;
         default: done_ok = 1'b0;
      endcase
   end

   assign timeout = busy & (wdog == WD_LAST) & ~done_ok;

   always_comb begin
      state_nx  = state;
      ready_nx  = frame_ready;
      frame_inc = 1'b0;
      fault_set = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick && enable) begin
               state_nx = frame_ready ? SWAP : CLEAR;
            end
         end
         SWAP: begin
            if (done_ok) begin
               state_nx = CLEAR;
               ready_nx = 1'b0;
            end
         end
         CLEAR: begin
            if (done_ok) begin
               state_nx = RENDER;
            end
         end
         RENDER: begin
            if (done_ok) begin
               state_nx  = IDLE;
               ready_nx  = 1'b1;
               frame_inc = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (timeout) begin
         state_nx  = IDLE;
         ready_nx  = 1'b0;
         fault_set = 1'b1;
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         frame_clk_d  <= 1'b1;
         frame_ready  <= 1'b0;
         wdog         <= '0;
         swap_start   <= 1'b0;
         clear_start  <= 1'b0;
         render_start <= 1'b0;
         frame_count  <= '0;
      end else begin
         frame_clk_d  <= frame_clk;
         frame_ready  <= ready_nx;
         swap_start   <= (state_nx == SWAP) && (state != SWAP);
         clear_start  <= (state_nx == CLEAR) && (state != CLEAR);
         render_start <= (state_nx == RENDER) && (state != RENDER);
         if (state_nx != state || state_nx == IDLE) begin
            wdog <= '0;
         end else begin
            wdog <= wdog + 1'b1;
         end
         if (frame_inc) begin
            frame_count <= frame_count + 1'b1;
         end
      end
   end

   // A tick landing on the clear cycle still counts as one fresh overrun.
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         overrun       <= 1'b0;
         overrun_count <= '0;
         fault         <= 1'b0;
      end else begin
         if (clr_status) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
            fault         <= 1'b0;
         end
         if (ovr_hit) begin
            overrun <= 1'b1;
            if (clr_status) begin
               overrun_count <= OVR_W'(1);
            end else if (overrun_count != '1) begin
               overrun_count <= overrun_count + 1'b1;
            end
         end
         if (fault_set) begin
            fault <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a short watchdog (16 cycles).
module tb_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_clk;
   logic        enable;
   logic        clr_status;
   logic        swap_done;
   logic        clear_done;
   logic        render_done;
   logic        swap_start;
   logic        clear_start;
   logic        render_start;
   logic        busy;
   logic [15:0] frame_count;
   logic        overrun;
   logic [7:0]  overrun_count;
   logic        fault;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   frame_sequencer #(
      .TIMEOUT_CYCLES(16),
      .FRAME_W(16),
      .OVR_W(8)
   ) dut (
      .clk_50mhz(clk),
      .rst(rst),
      .frame_clk(frame_clk),
      .enable(enable),
      .clr_status(clr_status),
      .swap_done(swap_done),
      .clear_done(clear_done),
      .render_done(render_done),
      .swap_start(swap_start),
      .clear_start(clear_start),
      .render_start(render_start),
      .busy(busy),
      .frame_count(frame_count),
      .overrun(overrun),
      .overrun_count(overrun_count),
      .fault(fault)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Low for one cycle, then high: tick lands in the second cycle.
   task automatic tick_frame();
      frame_clk = 1'b0;
      cyc(1);
      frame_clk = 1'b1;
      cyc(1);
   endtask

   // m = {render, clear, swap}
   task automatic pulse(input logic [2:0] m);
      {render_done, clear_done, swap_done} = m;
      cyc(1);
      {render_done, clear_done, swap_done} = 3'b000;
   endtask

   task automatic clr_pulse();
      clr_status = 1'b1;
      cyc(1);
      clr_status = 1'b0;
   endtask

   logic seen;

   initial begin
      rst = 1'b1;
      frame_clk = 1'b1;
      enable = 1'b1;
      clr_status = 1'b0;
      swap_done = 1'b0;
      clear_done = 1'b0;
      render_done = 1'b0;
      cyc(3);
      check("rst_busy", busy, 0);
      check("rst_fcnt", frame_count, 0);
      check("rst_ovr", overrun, 0);
      check("rst_ocnt", overrun_count, 0);
      check("rst_fault", fault, 0);
      check("rst_starts", {swap_start, clear_start, render_start}, 0);

      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         cyc(1);
         seen |= swap_start | clear_start | render_start | busy;
      end
      check("no_tick_high_at_release", seen, 0);

      // frame 1: not ready, goes straight to clear
      tick_frame();
      check("f1_clear_start", clear_start, 1);
      check("f1_no_swap", swap_start, 0);
      check("f1_busy", busy, 1);
      cyc(1);
      check("f1_clear_start_1cyc", clear_start, 0);
      cyc(2);
      pulse(3'b010);
      check("f1_render_start", render_start, 1);
      cyc(8);
      pulse(3'b100);
      check("f1_fcnt", frame_count, 1);
      check("f1_idle", busy, 0);

      // frame 2: ready, swap first
      tick_frame();
      check("f2_swap_start", swap_start, 1);
      check("f2_no_clear", clear_start, 0);
      cyc(2);
      pulse(3'b001);
      check("f2_clear_start", clear_start, 1);
      cyc(1);
      pulse(3'b010);
      check("f2_render_start", render_start, 1);
      cyc(1);
      pulse(3'b100);
      check("f2_fcnt", frame_count, 2);

      // frame 3: tick during render
      tick_frame();
      cyc(1);
      pulse(3'b001);
      cyc(1);
      pulse(3'b010);
      check("f3_render_start", render_start, 1);
      tick_frame();
      check("f3_overrun", overrun, 1);
      check("f3_ocnt", overrun_count, 1);
      check("f3_still_busy", busy, 1);
      check("f3_no_restart", {swap_start, clear_start, render_start}, 0);
      cyc(1);
      pulse(3'b100);
      check("f3_fcnt", frame_count, 3);

      // frame 4: clear never completes
      tick_frame();
      check("f4_swap_start", swap_start, 1);
      cyc(1);
      pulse(3'b001);
      check("f4_clear_start", clear_start, 1);
      cyc(15);
      check("wd_no_fault_early", fault, 0);
      check("wd_busy_early", busy, 1);
      cyc(1);
      check("wd_fault", fault, 1);
      check("wd_idle", busy, 0);
      check("wd_fcnt_kept", frame_count, 3);
      clr_pulse();
      check("clr_fault", fault, 0);
      check("clr_ovr", overrun, 0);
      check("clr_ocnt", overrun_count, 0);

      tick_frame();
      check("post_wd_clear", clear_start, 1);
      check("post_wd_no_swap", swap_start, 0);
      pulse(3'b010);
      check("done_on_start_ign", render_start, 0);
      check("done_on_start_busy", busy, 1);
      pulse(3'b100);
      check("stray_render_ign", render_start, 0);
      check("stray_render_busy", busy, 1);
      check("stray_render_fcnt", frame_count, 3);
      pulse(3'b010);
      check("f4b_render_start", render_start, 1);
      cyc(15);
      pulse(3'b100);
      check("wd_edge_fcnt", frame_count, 4);
      check("wd_edge_no_fault", fault, 0);
      check("wd_edge_idle", busy, 0);

      // frame 5: clr_status together with an overrun tick
      tick_frame();
      check("f5_swap_start", swap_start, 1);
      tick_frame();
      check("f5_ocnt1", overrun_count, 1);
      frame_clk = 1'b0;
      cyc(1);
      frame_clk = 1'b1;
      clr_status = 1'b1;
      cyc(1);
      clr_status = 1'b0;
      check("clr_tick_ovr", overrun, 1);
      check("clr_tick_ocnt", overrun_count, 1);
      cyc(1);
      pulse(3'b001);
      cyc(1);
      pulse(3'b010);
      cyc(1);
      pulse(3'b100);
      check("f5_fcnt", frame_count, 5);

      // saturation: fast ticks, frames keep timing out
      repeat (400) begin
         frame_clk = 1'b0;
         cyc(1);
         frame_clk = 1'b1;
         cyc(1);
      end
      check("sat_ocnt", overrun_count, 8'hff);
      check("sat_ovr", overrun, 1);
      frame_clk = 1'b0;
      cyc(40);
      check("sat_idle", busy, 0);
      check("sat_fault", fault, 1);
      check("sat_fcnt", frame_count, 5);
      clr_pulse();
      check("sat_clr", {overrun, overrun_count, fault}, 0);

      // disabled tick in IDLE is neither a frame nor an overrun
      enable = 1'b0;
      tick_frame();
      check("dis_no_start", {swap_start, clear_start, render_start}, 0);
      check("dis_idle", busy, 0);
      check("dis_no_ovr", overrun, 0);

      // enable dropped mid-frame does not abort
      enable = 1'b1;
      tick_frame();
      check("en_clear_start", clear_start, 1);
      enable = 1'b0;
      cyc(1);
      pulse(3'b010);
      cyc(1);
      pulse(3'b100);
      check("en_drop_fcnt", frame_count, 6);
      check("en_drop_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
